// File: rtl/argon_regfile_sequencer_if.sv
// Bundle of request, regfile bus and execute-unit signals of the sequencer.
// master: sequencer side; slave: decoder/regfile/ALU side.
interface argon_regfile_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             i_reqValid;
    logic             o_reqReady;
    logic [3:0]       i_reqRs1;
    logic [3:0]       i_reqRs2;
    logic [3:0]       i_reqRd;
    logic             i_reqWrite;
    logic [WIDTH-1:0] o_busData;
    logic             o_busValid;
    logic             o_selectLatch;
    logic             o_outputA;
    logic             o_outputB;
    logic             o_latchC;
    logic [WIDTH-1:0] i_rfData;
    logic             o_exValid;
    logic [WIDTH-1:0] o_exA;
    logic [WIDTH-1:0] o_exB;
    logic             i_exDone;
    logic [WIDTH-1:0] i_exResult;
    logic             o_done;
    logic             o_timeout;

    modport master (
        input  i_reqValid, i_reqRs1, i_reqRs2, i_reqRd, i_reqWrite,
        input  i_rfData, i_exDone, i_exResult,
        output o_reqReady, o_busData, o_busValid, o_selectLatch,
        output o_outputA, o_outputB, o_latchC,
        output o_exValid, o_exA, o_exB, o_done, o_timeout
    );

    modport slave (
        output i_reqValid, i_reqRs1, i_reqRs2, i_reqRd, i_reqWrite,
        output i_rfData, i_exDone, i_exResult,
        input  o_reqReady, o_busData, o_busValid, o_selectLatch,
        input  o_outputA, o_outputB, o_latchC,
        input  o_exValid, o_exA, o_exB, o_done, o_timeout
    );
endinterface

// File: rtl/argon_regfile_sequencer.sv
// Sequences one regfile op: select, read A, read B, execute, optional write-back.
// Ports: i_Clk, i_Reset_n (async, active-low), bus (argon_regfile_sequencer_if.master).
// Option: ARGON_REGSEQ_TIMEOUT_EN adds an EXEC wait limit of TIMEOUT_CYCLES with o_timeout.
module argon_regfile_sequencer #(
    parameter int WIDTH          = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic i_Clk,
    input  logic i_Reset_n,
    argon_regfile_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_READ_A,
        S_READ_B,
        S_CAP_B,
        S_EXEC,
        S_WRITE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [3:0]       rs1;
    logic [3:0]       rs2;
    logic [3:0]       rd;
    logic             wr;
    logic [WIDTH-1:0] ex_a;
    logic [WIDTH-1:0] ex_b;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] bus_data;
    logic             done_q;
    logic             done_nx;
    logic             to_q;
    logic             to_nx;
    logic             accept;
    logic             commit;

    assign accept = bus.i_reqValid && bus.o_reqReady;
    // Writes to r0 are dropped entirely: no WRITE cycle.
    assign commit = wr && (rd != 4'd0);

`ifdef ARGON_REGSEQ_TIMEOUT_EN
    localparam int CW_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CW     = (CW_RAW < 8) ? 8 : CW_RAW;

    logic [CW-1:0] cnt;

    // Zero whenever not in EXEC, so it starts cleared on every entry.
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            cnt <= '0;
        end else if (state != S_EXEC) begin
            cnt <= '0;
        end else if (!bus.i_exDone) begin
            cnt <= cnt + 1'b1;
        end
    end
`endif

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state  <= S_IDLE;
            rs1    <= '0;
            rs2    <= '0;
            rd     <= '0;
            wr     <= 1'b0;
            ex_a   <= '0;
            ex_b   <= '0;
            result <= '0;
            done_q <= 1'b0;
            to_q   <= 1'b0;
        end else begin
            state  <= state_nx;
            done_q <= done_nx;
            to_q   <= to_nx;
            if (accept) begin
                rs1 <= bus.i_reqRs1;
                rs2 <= bus.i_reqRs2;
                rd  <= bus.i_reqRd;
                wr  <= bus.i_reqWrite;
            end
            // Regfile output is registered: A appears during READ_B, B during CAP_B.
            if (state == S_READ_B) begin
                ex_a <= bus.i_rfData;
            end
            if (state == S_CAP_B) begin
                ex_b <= bus.i_rfData;
            end
            if (state == S_EXEC && bus.i_exDone) begin
                result <= bus.i_exResult;
            end
        end
    end

    always_comb begin
        state_nx = state;
        done_nx  = 1'b0;
        to_nx    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nx = S_SELECT;
                end
            end
            S_SELECT: state_nx = S_READ_A;
            S_READ_A: state_nx = S_READ_B;
            S_READ_B: state_nx = S_CAP_B;
            S_CAP_B:  state_nx = S_EXEC;
            S_EXEC: begin
                if (bus.i_exDone) begin
                    state_nx = commit ? S_WRITE : S_IDLE;
                    done_nx  = !commit;
                end
`ifdef ARGON_REGSEQ_TIMEOUT_EN
                else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                    state_nx = S_IDLE;
                    to_nx    = 1'b1;
                end
`endif
            end
            S_WRITE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        bus_data = '0;
        if (state == S_SELECT) begin
            bus_data = WIDTH'({rd, rs2, rs1});
        end else if (state == S_WRITE) begin
            bus_data = result;
        end
    end

    assign bus.o_reqReady    = (state == S_IDLE) && i_Reset_n;
    assign bus.o_busData     = bus_data;
    assign bus.o_busValid    = (state == S_SELECT) || (state == S_WRITE);
    assign bus.o_selectLatch = (state == S_SELECT);
    assign bus.o_outputA     = (state == S_READ_A);
    assign bus.o_outputB     = (state == S_READ_B);
    assign bus.o_latchC      = (state == S_WRITE);
    assign bus.o_exValid     = (state == S_EXEC);
    assign bus.o_exA         = ex_a;
    assign bus.o_exB         = ex_b;
    assign bus.o_done        = (state == S_WRITE) || done_q;
    assign bus.o_timeout     = to_q;

endmodule
